// File: rtl/ins_mem_server.sv
// Instruction-memory responder with zero-latency fetch and a byte-serial valid/ready loader.
// Optional macro INS_MEM_FAULT_EN adds a registered fetch_fault_out port.
module ins_mem_server #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic [31:0]                  mem_addr_in,
    output logic [31:0]                  mem_data_out,
    input  logic                         prog_start_in,
    input  logic                         prog_valid_in,
    input  logic [7:0]                   prog_byte_in,
    input  logic                         prog_last_in,
    output logic                         prog_ready_out,
    output logic                         prog_done_out,
    output logic [$clog2(DEPTH_WORDS):0] prog_words_out,
    output logic                         core_hold_out
`ifdef INS_MEM_FAULT_EN
    ,
    output logic                         fetch_fault_out
`endif
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] r_ptr;
    logic [1:0]    r_byte_cnt;
    logic [31:0]   r_shift;
    logic [AW:0]   r_words;

    logic          w_accept;
    logic          w_write;
    logic [31:0]   w_word;
    logic [32:0]   w_addr_ext;
    logic [32:0]   w_base_ext;
    logic [32:0]   w_limit;
    logic          w_in_range;
    logic          w_aligned;
    logic [AW-1:0] w_idx;

    assign w_accept = (r_state == S_LOAD) && prog_valid_in;
    assign w_write  = w_accept && ((r_byte_cnt == 2'd3) || prog_last_in);
    // Shift register is cleared at every word boundary, so unfilled upper bytes stay zero.
    assign w_word   = r_shift | ({24'd0, prog_byte_in} << {r_byte_cnt, 3'b000});

    // 33-bit compare keeps the upper bound from wrapping when the window ends at 2^32.
    assign w_addr_ext = {1'b0, mem_addr_in};
    assign w_base_ext = {1'b0, BASE_ADDR};
    assign w_limit    = w_base_ext + (33'(DEPTH_WORDS) << 2);
    assign w_in_range = (w_addr_ext >= w_base_ext) && (w_addr_ext < w_limit);
    assign w_aligned  = (mem_addr_in[1:0] == 2'b00);
    assign w_idx      = AW'((mem_addr_in - BASE_ADDR) >> 2);

    assign mem_data_out = ((r_state != S_LOAD) && w_aligned && w_in_range) ? r_mem[w_idx] : NOP_WORD;

    assign prog_ready_out = (r_state == S_LOAD);
    assign prog_done_out  = (r_state == S_DONE);
    assign core_hold_out  = (r_state != S_IDLE);
    assign prog_words_out = r_words;

    always_ff @(posedge clock_in) begin
        if (w_write && !reset_in) begin
            r_mem[r_ptr] <= w_word;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_words    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (prog_start_in) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_byte_cnt <= '0;
                        r_shift    <= '0;
                        r_words    <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_write) begin
                            r_ptr      <= r_ptr + 1'b1;
                            r_words    <= r_words + 1'b1;
                            r_byte_cnt <= '0;
                            r_shift    <= '0;
                            if (prog_last_in || (r_ptr == AW'(DEPTH_WORDS - 1))) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_shift    <= w_word;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef INS_MEM_FAULT_EN
    logic r_fault;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (r_state != S_LOAD) && !(w_aligned && w_in_range);
        end
    end

    assign fetch_fault_out = r_fault;
`endif

endmodule

// File: tb/tb_ins_mem_server.sv
// Directed bench for ins_mem_server: loader image tests plus a fetch-vector table.
// Fault-port checks are compiled only when INS_MEM_FAULT_EN is defined.
module tb_ins_mem_server;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        prog_start;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_last;
    logic        prog_ready;
    logic        prog_done;
    logic [10:0] prog_words;
    logic        core_hold;
`ifdef INS_MEM_FAULT_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    ins_mem_server #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (32'h0000_0000),
        .NOP_WORD   (NOP)
    ) dut (
        .clock_in      (clk),
        .reset_in      (reset),
        .mem_addr_in   (mem_addr),
        .mem_data_out  (mem_data),
        .prog_start_in (prog_start),
        .prog_valid_in (prog_valid),
        .prog_byte_in  (prog_byte),
        .prog_last_in  (prog_last),
        .prog_ready_out(prog_ready),
        .prog_done_out (prog_done),
        .prog_words_out(prog_words),
        .core_hold_out (core_hold)
`ifdef INS_MEM_FAULT_EN
        ,
        .fetch_fault_out(fetch_fault)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } fetch_vec_t;

    fetch_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input logic last);
        prog_valid = 1'b1;
        prog_byte  = b;
        prog_last  = last;
        step();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic start_load();
        prog_start = 1'b1;
        step();
        prog_start = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        mem_addr = addr;
        #1;
        chk(name, mem_data, exp);
    endtask

    // Byte stream for the full-depth load.
    function automatic logic [7:0] fb(input int unsigned i);
        return 8'(i ^ (i >> 8));
    endfunction

    function automatic logic [31:0] fw(input int unsigned first);
        return {fb(first + 3), fb(first + 2), fb(first + 1), fb(first)};
    endfunction

    logic [7:0] img1 [8];

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, data: 32'h0000_0013, fault: 1'b0};
        vecs[1] = '{addr: 32'h0000_0004, data: 32'h0010_0093, fault: 1'b0};
        vecs[2] = '{addr: 32'h0000_0006, data: NOP,           fault: 1'b1};
        vecs[3] = '{addr: 4 * DEPTH,     data: NOP,           fault: 1'b1};
        vecs[4] = '{addr: 32'hFFFF_FFFC, data: NOP,           fault: 1'b1};
        vecs[5] = '{addr: 32'h0000_0003, data: NOP,           fault: 1'b1};
        img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        reset      = 1'b1;
        mem_addr   = '0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_byte  = '0;
        prog_last  = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(prog_ready), 32'd0);
        chk("rst_done",  32'(prog_done),  32'd0);
        chk("rst_words", 32'(prog_words), 32'd0);
        chk("rst_hold",  32'(core_hold),  32'd0);
`ifdef INS_MEM_FAULT_EN
        chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        reset = 1'b0;
        step();

        // Test 1: two-word image, last on the final byte of a full word
        start_load();
        chk("t1_hold_load",  32'(core_hold),  32'd1);
        chk("t1_ready_load", 32'(prog_ready), 32'd1);
        chk("t1_words_start", 32'(prog_words), 32'd0);
        fetch_chk("t1_nop_in_load", 32'h0, NOP);
        for (int i = 0; i < 8; i++) begin
            put(img1[i], i == 7);
        end
        chk("t1_done",       32'(prog_done),  32'd1);
        chk("t1_words",      32'(prog_words), 32'd2);
        chk("t1_ready_done", 32'(prog_ready), 32'd0);
        chk("t1_hold_done",  32'(core_hold),  32'd1);
        step();
        chk("t1_done_once",  32'(prog_done),  32'd0);
        chk("t1_hold_drop",  32'(core_hold),  32'd0);

        // Test 2: fetch table
        for (int i = 0; i < 6; i++) begin
            fetch_chk($sformatf("t2_data[%0d]", i), vecs[i].addr, vecs[i].data);
`ifdef INS_MEM_FAULT_EN
            step();
            chk($sformatf("t2_fault[%0d]", i), 32'(fetch_fault), 32'(vecs[i].fault));
`endif
        end

        // Test 3: partial final word is zero-filled
        start_load();
        put(8'hAA, 1'b0);
        put(8'hBB, 1'b0);
        put(8'hCC, 1'b0);
        put(8'hDD, 1'b0);
        put(8'hEE, 1'b1);
        chk("t3_done",  32'(prog_done),  32'd1);
        chk("t3_words", 32'(prog_words), 32'd2);
        step();
        fetch_chk("t3_mem0", 32'h0, 32'hDDCC_BBAA);
        fetch_chk("t3_mem1", 32'h4, 32'h0000_00EE);

        // Test 4: full-depth load with no last, extra bytes refused
        start_load();
        for (int unsigned i = 1; i <= 4 * DEPTH; i++) begin
            put(fb(i), 1'b0);
            if (i == 4 * DEPTH - 1) begin
                chk("t4_ready_before_end", 32'(prog_ready), 32'd1);
            end
        end
        chk("t4_ready_end", 32'(prog_ready), 32'd0);
        chk("t4_done",      32'(prog_done),  32'd1);
        chk("t4_words",     32'(prog_words), 32'(DEPTH));
        for (int unsigned i = 4 * DEPTH + 1; i <= 4 * DEPTH + 4; i++) begin
            put(fb(i), 1'b0);
            chk($sformatf("t4_extra_ready[%0d]", i), 32'(prog_ready), 32'd0);
            chk($sformatf("t4_extra_words[%0d]", i), 32'(prog_words), 32'(DEPTH));
        end
        chk("t4_hold_after", 32'(core_hold), 32'd0);
        fetch_chk("t4_mem_last", 4 * (DEPTH - 1), fw(4 * DEPTH - 3));
        fetch_chk("t4_mem_last_k", 4 * (DEPTH - 1), 32'h10F0_F1F2);
        fetch_chk("t4_mem0",   32'h0, fw(1));
        fetch_chk("t4_mem511", 4 * 511, fw(4 * 511 + 1));

        // Test 5: reset mid-load keeps the completed word, drops the partial one
        start_load();
        for (int i = 0; i < 6; i++) begin
            put(8'(8'h11 + i), 1'b0);
        end
        reset = 1'b1;
        step();
        chk("t5_hold",  32'(core_hold),  32'd0);
        chk("t5_ready", 32'(prog_ready), 32'd0);
        chk("t5_done",  32'(prog_done),  32'd0);
        chk("t5_words", 32'(prog_words), 32'd0);
        reset = 1'b0;
        step();
        fetch_chk("t5_mem0", 32'h0, 32'h1413_1211);
        fetch_chk("t5_mem1", 32'h4, fw(5));

        // Test 6: throttled valid with start re-pulsed mid-load
        start_load();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 2) begin
                prog_start = 1'b1;
            end
            step();
            prog_start = 1'b0;
            put(8'(8'hA1 + i), i == 7);
        end
        chk("t6_done",  32'(prog_done),  32'd1);
        chk("t6_words", 32'(prog_words), 32'd2);
        step();
        chk("t6_hold",  32'(core_hold),  32'd0);
        fetch_chk("t6_mem0", 32'h0, 32'hA4A3_A2A1);
        fetch_chk("t6_mem1", 32'h4, 32'hA8A7_A6A5);
        fetch_chk("t6_mem2", 32'h8, fw(9));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
